vc_buffer_ctrl: RTL and testbench
=================================

// Module: vc_buffer_ctrl
// PURPOSE
//  Controller for one router input port: V virtual-channel FIFOs share one fifo_ram (SSA_EN="NO").
//  Keeps per-VC head/tail pointers and occupancy, and drives the RAM address, write and read strobes.
//  Flags over/underflow and returns one credit upstream per flit read out.
//  Sits between link input and switch allocator/crossbar.
// PARAMETERS
//  V           4    number of VCs, power of 2, >=2
//  B           4    flits per VC, power of 2, >=2
//  FLIT_W      32   flit width
//  (local) VW=log2(V), BW=log2(B), RAM ADDR_WIDTH=VW+BW, address={vc_idx,ptr}
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       async, active-low; asserting clears all state immediately
//  flit_in         in   FLIT_W  incoming flit
//  flit_in_wr      in   1       write request
//  vc_num_in       in   V       one-hot target VC of write
//  rd_en           in   1       read request from crossbar
//  rd_vc           in   V       one-hot VC to read
//  flit_out        out  FLIT_W  RAM read data
//  flit_out_valid  out  1       flit_out valid, 1 cycle after accepted read
//  vc_not_empty    out  V       per-VC occupancy>0
//  vc_full         out  V       per-VC occupancy==B
//  credit_out      out  1       pulse per accepted read
//  credit_vc       out  V       one-hot VC of credit_out (0 when no pulse)
//  wr_ovf_err      out  1       pulse: write to full VC or non-one-hot vc_num_in
//  rd_unf_err      out  1       pulse: read of empty VC or non-one-hot rd_vc
// BEHAVIOUR
//  Reset: all pointers/counters 0; vc_not_empty=0, vc_full=0, every pulse/valid output 0.
//  Write accepted iff flit_in_wr & onehot(vc_num_in) & !vc_full[v]:
//   RAM wr_en=1, wr_addr={v,tail[v]}, wr_data=flit_in (comb. same cycle); tail[v]++ mod B.
//  Read accepted iff rd_en & onehot(rd_vc) & vc_not_empty[v]:
//   RAM rd_en=1, rd_addr={v,head[v]} (comb.); head[v]++ mod B;
//   next cycle: flit_out_valid=1, credit_out=1, credit_vc=rd_vc (registered).
//  Latency: write->vc_not_empty: 1 cycle; write->flit_out earliest 2 cycles (no bypass).
//  Occupancy cnt[v] is BW+1 bits: +1 on accepted wr only, -1 on accepted rd only,
//   unchanged when both hit same VC. Status flags decode registered cnt (no comb. in->out path).
//  Same VC, wr+rd same cycle: full -> write rejected (wr_ovf_err), read proceeds;
//   empty -> read rejected (rd_unf_err), write proceeds. Different VCs: both proceed.
//  Rejected ops: no state change, no RAM strobe; error pulse registered, 1 cycle later.
//  Zero-hot selects with req low: idle, no error. Pointers wrap B-1->0 silently.
//  flit_out holds last read value when flit_out_valid=0 (RAM keeps it).
//  Reset mid-operation: buffered flits discarded; in-flight valid/credit/err pulses cancelled.
// STRUCTURE
//  Shared pkg/define: log2 function, onehot check function, VC index encode function.
//  Sub-module vc_ptr_ctrl (one per VC, generate loop): head, tail, cnt, not_empty, full.
//  Top: select decode, accept logic, address mux, output registers, one fifo_ram instance.
// TESTING (V=4,B=4,FLIT_W=32)
//  1 reset; 4 wr VC0 0xA0..0xA3 -> vc_full=0001; 4 rd VC0 -> flit_out A0..A3 in order, 4 credits credit_vc=0001.
//  2 fill VC2, 5th wr 0xDEAD -> wr_ovf_err 1 pulse, cnt stays 4, later reads never return 0xDEAD.
//  3 rd VC1 empty -> rd_unf_err pulse, no flit_out_valid, no credit, pointers unchanged.
//  4 VC3 occ 2, same-cycle wr+rd VC3 -> occ 2, correct flit out; VC3 empty + wr/rd same cycle -> unf err, occ 1.
//  5 10 wr/rd cycles on VC1 at occ 1..3 -> wrap B-1->0, data order preserved, no cross-VC corruption.
//  6 reset low mid-stream with 3 flits held -> all outputs 0 at once; after release vc_not_empty=0000.

Source files
------------

// File: rtl/vc_buffer_ctrl_pkg.sv
// Shared helpers for the virtual-channel input buffer: sizing, select validation and decode.
// Select helpers take selects up to 32 bits wide, zero-extended by the caller.
package vc_buffer_ctrl_pkg;

    localparam int MAX_V = 32;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_V-1:0] x);
        return (x != '0) && ((x & (x - 1'b1)) == '0);
    endfunction

    function automatic int onehot_idx(input logic [MAX_V-1:0] x);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_V; i++) begin
            if (x[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Shared flit storage: one synchronous write port and one synchronous read port.
// The read register holds its value until the next read strobe.
module fifo_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; stale words are never read because
    // the pointer/occupancy logic only reads slots that were written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vc_ptr_ctrl.sv
// Per-VC bookkeeping: head/tail pointers and occupancy with decoded status.
// Callers only assert wr/rd for accepted operations, so no guarding is needed here.
import vc_buffer_ctrl_pkg::*;

module vc_ptr_ctrl #(
    parameter int B  = 4,
    parameter int BW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    output logic [BW-1:0] head,
    output logic [BW-1:0] tail,
    output logic          not_empty,
    output logic          full
);

    logic [BW:0] cnt;

    // Pointers are BW bits wide and B is a power of two, so they wrap silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (wr) tail <= tail + 1'b1;
            if (rd) head <= head + 1'b1;
            if (wr && !rd)      cnt <= cnt + 1'b1;
            else if (rd && !wr) cnt <= cnt - 1'b1;
        end
    end

    assign not_empty = (cnt != '0);
    assign full      = (cnt == (BW+1)'(B));

endmodule

// File: rtl/vc_buffer_ctrl.sv
// Input-port buffer controller: V virtual-channel FIFOs sharing one flit RAM
// addressed as {vc_idx, ptr}, with credit return and over/underflow pulses.
import vc_buffer_ctrl_pkg::*;

module vc_buffer_ctrl #(
    parameter int V      = 4,
    parameter int B      = 4,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_wr,
    input  logic [V-1:0]      vc_num_in,
    input  logic              rd_en,
    input  logic [V-1:0]      rd_vc,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid,
    output logic [V-1:0]      vc_not_empty,
    output logic [V-1:0]      vc_full,
    output logic              credit_out,
    output logic [V-1:0]      credit_vc,
    output logic              wr_ovf_err,
    output logic              rd_unf_err
);

    localparam int VW = log2(V);
    localparam int BW = log2(B);
    localparam int AW = VW + BW;

    logic [BW-1:0] head [V];
    logic [BW-1:0] tail [V];

    logic          wr_sel_ok, rd_sel_ok;
    logic [VW-1:0] wr_idx, rd_idx;
    logic          wr_ok, rd_ok;
    logic [V-1:0]  wr_vec, rd_vec;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;

    assign wr_sel_ok = is_onehot(MAX_V'(vc_num_in));
    assign rd_sel_ok = is_onehot(MAX_V'(rd_vc));
    assign wr_idx    = VW'(onehot_idx(MAX_V'(vc_num_in)));
    assign rd_idx    = VW'(onehot_idx(MAX_V'(rd_vc)));

    // Same-VC collisions resolve themselves: a full VC blocks only the write,
    // an empty VC blocks only the read, because each test uses registered status.
    assign wr_ok  = flit_in_wr && wr_sel_ok && !vc_full[wr_idx];
    assign rd_ok  = rd_en && rd_sel_ok && vc_not_empty[rd_idx];
    assign wr_vec = {V{wr_ok}} & vc_num_in;
    assign rd_vec = {V{rd_ok}} & rd_vc;

    assign ram_wr_addr = {wr_idx, tail[wr_idx]};
    assign ram_rd_addr = {rd_idx, head[rd_idx]};

    for (genvar g = 0; g < V; g++) begin : g_vc
        vc_ptr_ctrl #(
            .B  (B),
            .BW (BW)
        ) u_ptr (
            .clk       (clk),
            .reset     (reset),
            .wr        (wr_vec[g]),
            .rd        (rd_vec[g]),
            .head      (head[g]),
            .tail      (tail[g]),
            .not_empty (vc_not_empty[g]),
            .full      (vc_full[g])
        );
    end

    fifo_ram #(
        .DATA_W (FLIT_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (ram_wr_addr),
        .wr_data (flit_in),
        .rd_en   (rd_ok),
        .rd_addr (ram_rd_addr),
        .rd_data (flit_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_out_valid <= 1'b0;
            credit_out     <= 1'b0;
            credit_vc      <= '0;
            wr_ovf_err     <= 1'b0;
            rd_unf_err     <= 1'b0;
        end else begin
            flit_out_valid <= rd_ok;
            credit_out     <= rd_ok;
            credit_vc      <= rd_vec;
            wr_ovf_err     <= flit_in_wr && !wr_ok;
            rd_unf_err     <= rd_en && !rd_ok;
        end
    end

endmodule

// File: tb/tb_vc_buffer_ctrl.sv
// Scoreboard bench for vc_buffer_ctrl: directed scenarios then random traffic,
// checked against per-VC flit queues.
module tb_vc_buffer_ctrl;

    localparam int V      = 4;
    localparam int B      = 4;
    localparam int FLIT_W = 32;

    typedef struct {
        logic [FLIT_W-1:0] data;
        logic [V-1:0]      vc;
    } rd_exp_t;

    typedef struct {
        logic         valid;
        logic         ovf;
        logic         unf;
        logic [V-1:0] not_empty;
        logic [V-1:0] full;
    } cyc_exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic              flit_in_wr = 1'b0;
    logic [V-1:0]      vc_num_in = '0;
    logic              rd_en = 1'b0;
    logic [V-1:0]      rd_vc = '0;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_out_valid;
    logic [V-1:0]      vc_not_empty;
    logic [V-1:0]      vc_full;
    logic              credit_out;
    logic [V-1:0]      credit_vc;
    logic              wr_ovf_err;
    logic              rd_unf_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [FLIT_W-1:0] mdl [V][$];
    rd_exp_t           exp_rd_q [$];
    cyc_exp_t          exp_cyc_q [$];

    vc_buffer_ctrl #(.V(V), .B(B), .FLIT_W(FLIT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flit_in        (flit_in),
        .flit_in_wr     (flit_in_wr),
        .vc_num_in      (vc_num_in),
        .rd_en          (rd_en),
        .rd_vc          (rd_vc),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .vc_not_empty   (vc_not_empty),
        .vc_full        (vc_full),
        .credit_out     (credit_out),
        .credit_vc      (credit_vc),
        .wr_ovf_err     (wr_ovf_err),
        .rd_unf_err     (rd_unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int oh_idx(input logic [V-1:0] x);
        int r;
        r = 0;
        for (int i = 0; i < V; i++) if (x[i]) r = i;
        return r;
    endfunction

    function automatic logic [V-1:0] rand_sel();
        if ($urandom_range(0, 9) == 0) return V'($urandom);
        return V'(1) << $urandom_range(0, V-1);
    endfunction

    // One clock of stimulus; the model decides acceptance from pre-cycle occupancy.
    task automatic step(input logic wr, input logic [V-1:0] wv, input logic [FLIT_W-1:0] d,
                        input logic rd, input logic [V-1:0] rv);
        cyc_exp_t ce;
        rd_exp_t  re;
        int       wi, ri;
        bit       w_ok, r_ok;
        @(negedge clk);
        flit_in_wr = wr;
        vc_num_in  = wv;
        flit_in    = d;
        rd_en      = rd;
        rd_vc      = rv;
        wi   = oh_idx(wv);
        ri   = oh_idx(rv);
        w_ok = wr && ($countones(wv) == 1) && (mdl[wi].size() < B);
        r_ok = rd && ($countones(rv) == 1) && (mdl[ri].size() > 0);
        if (r_ok) begin
            re.data = mdl[ri].pop_front();
            re.vc   = rv;
            exp_rd_q.push_back(re);
        end
        if (w_ok) mdl[wi].push_back(d);
        ce.valid = r_ok;
        ce.ovf   = wr && !w_ok;
        ce.unf   = rd && !r_ok;
        for (int i = 0; i < V; i++) begin
            ce.not_empty[i] = (mdl[i].size() > 0);
            ce.full[i]      = (mdl[i].size() == B);
        end
        exp_cyc_q.push_back(ce);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic clear_model();
        exp_rd_q.delete();
        exp_cyc_q.delete();
        for (int i = 0; i < V; i++) mdl[i].delete();
    endtask

    // Monitor: compares registered outputs shortly after each rising edge.
    initial begin
        cyc_exp_t ce;
        rd_exp_t  re;
        forever begin
            @(posedge clk);
            #2;
            if (reset && exp_cyc_q.size() > 0) begin
                ce = exp_cyc_q.pop_front();
                check("flit_out_valid", 64'(flit_out_valid), 64'(ce.valid));
                check("credit_out", 64'(credit_out), 64'(ce.valid));
                check("wr_ovf_err", 64'(wr_ovf_err), 64'(ce.ovf));
                check("rd_unf_err", 64'(rd_unf_err), 64'(ce.unf));
                check("vc_not_empty", 64'(vc_not_empty), 64'(ce.not_empty));
                check("vc_full", 64'(vc_full), 64'(ce.full));
                if (flit_out_valid) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_flit", 64'(flit_out), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        re = exp_rd_q.pop_front();
                        check("flit_out", 64'(flit_out), 64'(re.data));
                        check("credit_vc", 64'(credit_vc), 64'(re.vc));
                    end
                end else begin
                    check("credit_vc_idle", 64'(credit_vc), 64'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, fill VC0, drain in order
        #12;
        check("rst_not_empty", 64'(vc_not_empty), 64'(0));
        check("rst_full", 64'(vc_full), 64'(0));
        check("rst_valid", 64'(flit_out_valid), 64'(0));
        check("rst_credit", 64'(credit_out), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, 32'hA0 + i, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 4'b0001);
        idle(2);

        // 2: fill VC2, overflow write is dropped
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0100, 32'hC0 + i, 1'b0, '0);
        step(1'b1, 4'b0100, 32'hDEAD, 1'b0, '0);
        idle(1);

        // 3: read of empty VC1, and non-one-hot / zero-hot selects
        step(1'b0, '0, '0, 1'b1, 4'b0010);
        step(1'b1, 4'b0011, 32'h55, 1'b1, 4'b0000);
        idle(1);

        // 4: VC3 simultaneous wr+rd at occupancy 2, then at occupancy 0
        step(1'b1, 4'b1000, 32'hD0, 1'b0, '0);
        step(1'b1, 4'b1000, 32'hD1, 1'b0, '0);
        step(1'b1, 4'b1000, 32'hD2, 1'b1, 4'b1000);
        step(1'b0, '0, '0, 1'b1, 4'b1000);
        step(1'b0, '0, '0, 1'b1, 4'b1000);
        step(1'b1, 4'b1000, 32'hD3, 1'b1, 4'b1000);
        step(1'b0, '0, '0, 1'b1, 4'b1000);
        idle(1);

        // 5: VC1 streaming across pointer wrap while VC2 stays full, then drain VC2
        step(1'b1, 4'b0010, 32'hB0, 1'b0, '0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'b0010, 32'hB1 + i, (i % 5 != 2), 4'b0010);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 4'b0100);
        idle(2);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, rand_sel(), $urandom,
                 $urandom_range(0, 9) < 5, rand_sel());
        for (int i = 0; i < V; i++)
            for (int k = 0; k < B; k++) step(1'b0, '0, '0, 1'b1, V'(1) << i);
        idle(2);
        @(posedge clk);
        #3;
        check("drain_rd_q", 64'(exp_rd_q.size()), 64'(0));

        // 6: reset mid-stream with a read in flight and three flits held
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, 32'hE0 + i, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 4'b0001);
        @(posedge clk);
        #3;
        reset = 1'b0;
        clear_model();
        flit_in_wr = 1'b0;
        rd_en      = 1'b0;
        #1;
        check("mid_rst_valid", 64'(flit_out_valid), 64'(0));
        check("mid_rst_credit", 64'(credit_out), 64'(0));
        check("mid_rst_credit_vc", 64'(credit_vc), 64'(0));
        check("mid_rst_errs", 64'({wr_ovf_err, rd_unf_err}), 64'(0));
        check("mid_rst_not_empty", 64'(vc_not_empty), 64'(0));
        check("mid_rst_full", 64'(vc_full), 64'(0));
        check("mid_rst_flit_out", 64'(flit_out), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        step(1'b0, '0, '0, 1'b1, 4'b0001);
        idle(2);
        @(posedge clk);
        #3;
        check("post_rst_not_empty", 64'(vc_not_empty), 64'(0));
        check("final_rd_q", 64'(exp_rd_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
